countdown_timer: RTL and testbench
==================================

# countdown_timer

Programmable down-counting timer: the decrementing counterpart to the team's free-running up-counters. A load handshake sets a start value. The block counts down once per cycle to expiry and pulses `expired` at terminal count. It either stops (one-shot) or reloads (periodic). Used as the timeout/period source beside the existing counters in the same clock domain.

## Interface
- `WIDTH`, 8, width of load value and `count`
- `EXP_W`, 4, width of the wrapping expiry tally
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous, active-high reset
- `load_valid` in 1, load request
- `load_ready` out 1, block can accept a load
- `load_value` in WIDTH, start/reload value, sampled on handshake
- `periodic` in 1, mode, sampled on handshake (1 = reload at expiry)
- `pause` in 1, level, holds the count while high
- `abort` in 1, level, cancels the running timer
- `count` out WIDTH, current remaining count (registered)
- `busy` out 1, state is RUN or PAUSE
- `paused` out 1, state is PAUSE
- `expired` out 1, single-cycle expiry pulse (registered)
- `expiries` out EXP_W, number of expiries since last load; wraps

## Operation
- FSM states: IDLE, RUN, PAUSE. Reset state is IDLE. Reset values: `count`=0, `expired`=0, `expiries`=0, `busy`=0, `paused`=0, and `load_ready`=1 once `rst` deasserts.
- `load_ready` = (state==IDLE) && !`abort`, combinational.
- Handshake is `load_valid && load_ready` at a rising edge. It captures `load_value` into `count` and the reload register, captures `periodic` into the mode register, and clears `expiries`.
  - `load_value`≠0: next state RUN.
  - `load_value`==0: state stays IDLE, `expired`=1 for one cycle, `expiries`=1. Never loops, even in periodic mode.
- Decrement enable = busy && !`pause` && !`abort`. Transitions into and out of PAUSE follow `pause` each edge. The edge leaving PAUSE also decrements, so there is no bubble.
  - RUN → PAUSE when `pause`=1.
  - PAUSE → RUN when `pause`=0.
- Terminal step is an enabled edge with `count`==1:
  - One-shot: `count`→0, state→IDLE, `expired`=1.
  - Periodic: `count`→reload value (never shows 0), state unchanged, `expired`=1.
  - `expiries` increments modulo 2^EXP_W on every `expired` pulse.
- `abort` has highest priority after `rst`. At an edge with `abort`=1: state→IDLE, `count`→0, no `expired` pulse, `expiries` holds. `load_valid` in the same cycle is not accepted.
- `pause` while IDLE has no effect.
- `count` never underflows; decrement only occurs when `count`>0.

## Timing
- With a handshake at edge E and load N≥1, no pause: `count`=N−k after edge E+k. `expired`=1 in the cycle following edge E+N.
- In one-shot mode, `load_ready` is 1 in that same cycle, so a back-to-back load can be accepted at edge E+N+1.
- Periodic period is exactly N cycles. `expired` is high in cycles E+N, E+2N, and so on.
- Each cycle with `pause`=1 while busy adds exactly one cycle to expiry.
- `rst` mid-operation forces all reset values at the next edge, regardless of other inputs.
- All outputs except `load_ready` are registered. No combinational path runs from `load_valid` to any output.

## Structure
- Package `countdown_pkg`: state enum typedef (IDLE, RUN, PAUSE) and default width constants.
- One sub-module: `expiry_counter`, an EXP_W-bit wrapping up-counter with synchronous clear (load) and enable (`expired`). The top level instantiates it.
- The FSM, reload register, and decrement datapath live in the top level.

## Test plan
- One-shot, WIDTH=8: load 5 → `count` 5,4,3,2,1,0. `expired` pulses once, 5 cycles after the handshake. `busy` falls and `load_ready`=1 in the pulse cycle. `expiries`=1.
- Periodic load 3, run 50 cycles:
  - `count` cycles 3,2,1,3,…
  - `expired` every 3rd cycle.
  - With EXP_W=4, `expiries` wraps 15→0 on the 16th pulse.
- Pause: load 4, hold `pause` for 3 cycles when `count`=2 → `count` holds at 2, `paused`=1, expiry arrives at handshake+7.
- Load 0 with `periodic`=1 → `busy` stays 0, exactly one `expired` pulse, `expiries`=1, no further pulses.
- Abort: load 10, assert `abort` at `count`=6 together with `load_valid` (value 9) → IDLE, `count`=0, no `expired`, load not taken. The next cycle, the load of 9 is accepted.
- Reset mid-run: periodic load 200, assert `rst` at `count`=197 → next cycle all outputs at reset values.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg
//   Shared definitions for the countdown timer block.
//   - state_e       : timer FSM states (IDLE, RUN, PAUSE)
//   - DEFAULT_WIDTH : default width of the load value / remaining count
//   - DEFAULT_EXP_W : default width of the wrapping expiry tally
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_EXP_W = 4;

endpackage : countdown_pkg

// File: rtl/expiry_counter.sv
// expiry_counter
//   EXP_W-bit wrapping up-counter that tallies expiry pulses since the last load.
//   Ports:
//     clk      in  : rising-edge clock
//     rst      in  : synchronous active-high reset, clears the tally
//     clear_i  in  : synchronous clear (load accepted)
//     en_i     in  : count one event this edge
//     count_o  out : current tally (registered, wraps modulo 2^EXP_W)
module expiry_counter
    import countdown_pkg::*;
#(
    parameter int EXP_W = DEFAULT_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [EXP_W-1:0] count_o
);

    localparam logic [EXP_W-1:0] TALLY_ONE = EXP_W'(1);

    logic [EXP_W-1:0] count_q;
    logic [EXP_W-1:0] count_d;

    // A clear and an event on the same edge means a zero-value load that
    // expires immediately: the tally restarts at one, not zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = en_i ? TALLY_ONE : '0;
        end else if (en_i) begin
            count_d = count_q + TALLY_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : expiry_counter

// File: rtl/countdown_timer.sv
// countdown_timer
//   Programmable down-counting timer with one-shot and periodic modes.
//   A load handshake sets the start value; the count decrements once per
//   enabled cycle and a single-cycle expiry pulse marks terminal count.
//   Ports:
//     clk        in  : rising-edge clock
//     rst        in  : synchronous active-high reset
//     load_valid in  : load request
//     load_ready out : block can accept a load (combinational)
//     load_value in  : start/reload value, sampled on handshake
//     periodic   in  : mode, sampled on handshake (1 = reload at expiry)
//     pause      in  : level, holds the count while high
//     abort      in  : level, cancels the running timer
//     count      out : remaining count (registered)
//     busy       out : timer is running or paused
//     paused     out : timer is paused
//     expired    out : single-cycle expiry pulse (registered)
//     expiries   out : expiries since last load, wrapping
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int EXP_W = DEFAULT_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             expired,
    output logic [EXP_W-1:0] expiries
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] reload_q,   reload_d;
    logic             periodic_q, periodic_d;
    logic             expired_q,  expired_d;
    logic             tally_clear;

    assign load_ready = (state_q == IDLE) && !abort;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        periodic_d  = periodic_q;
        expired_d   = 1'b0;
        tally_clear = 1'b0;

        if (abort) begin
            // Cancel outright: no pulse, tally untouched, any load refused.
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        reload_d    = load_value;
                        periodic_d  = periodic;
                        count_d     = load_value;
                        tally_clear = 1'b1;
                        // A zero load expires on the spot and never reloads.
                        if (load_value == '0) begin
                            expired_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN, PAUSE: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else begin
                        // Leaving PAUSE decrements on the same edge.
                        state_d = RUN;
                        if (count_q == CNT_ONE) begin
                            expired_d = 1'b1;
                            if (periodic_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
        end
    end

    expiry_counter #(
        .EXP_W (EXP_W)
    ) u_expiry_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tally_clear),
        .en_i    (expired_d),
        .count_o (expiries)
    );

    assign count   = count_q;
    assign busy    = (state_q != IDLE);
    assign paused  = (state_q == PAUSE);
    assign expired = expired_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Self-checking bench: directed scenarios with literal expectations plus a
//   randomized phase, all compared every cycle against a behavioural model
//   that tracks "enabled steps since load" rather than a state register.
module tb_countdown_timer;

    localparam int WIDTH = 8;
    localparam int EXP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_value = '0;
    logic             periodic = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             expired;
    logic [EXP_W-1:0] expiries;

    int n_checks = 0;
    int n_pass   = 0;

    countdown_timer #(
        .WIDTH (WIDTH),
        .EXP_W (EXP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .periodic   (periodic),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .paused     (paused),
        .expired    (expired),
        .expiries   (expiries)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_n: loaded value, m_k: number of enabled (decrementing) edges since load.
    // One-shot: remaining = N - k, done at k == N.
    // Periodic: remaining = N - (k mod N), expiry whenever k is a multiple of N,
    //           total expiries = k / N.
    bit m_busy, m_paused, m_per, m_pulse;
    int m_n, m_k, m_total, m_count;

    initial begin
        m_busy = 0; m_paused = 0; m_per = 0; m_pulse = 0;
        m_n = 0; m_k = 0; m_total = 0; m_count = 0;
    end

    function automatic void model_step();
        if (rst) begin
            m_busy = 0; m_paused = 0; m_pulse = 0;
            m_k = 0; m_total = 0; m_count = 0;
        end else if (abort) begin
            m_busy = 0; m_paused = 0; m_pulse = 0; m_count = 0;
        end else if (!m_busy) begin
            m_pulse = 0;
            if (load_valid) begin
                m_n = int'(load_value);
                m_per = periodic;
                m_k = 0;
                m_count = m_n;
                if (m_n == 0) begin
                    m_pulse = 1;
                    m_total = 1;
                end else begin
                    m_busy = 1;
                    m_total = 0;
                end
            end
        end else if (pause) begin
            m_paused = 1;
            m_pulse = 0;
        end else begin
            m_paused = 0;
            m_k++;
            if (m_per) begin
                m_count = m_n - (m_k % m_n);
                m_pulse = (m_k % m_n == 0);
                m_total = m_k / m_n;
            end else begin
                m_count = m_n - m_k;
                m_pulse = (m_k == m_n);
                m_total = m_pulse ? 1 : 0;
                if (m_pulse) m_busy = 0;
            end
        end
    endfunction

    // Model advances on every edge using the inputs held across it; the DUT
    // outputs are sampled 1 time unit later.
    always @(posedge clk) begin
        model_step();
        #1;
        check("count",      int'(count),    m_count);
        check("busy",       int'(busy),     int'(m_busy));
        check("paused",     int'(paused),   int'(m_paused));
        check("expired",    int'(expired),  int'(m_pulse));
        check("expiries",   int'(expiries), m_total % (1 << EXP_W));
        if (!rst) check("load_ready", int'(load_ready), int'(!m_busy && !abort));
    end

    // Apply inputs, let one edge consume them, return 2 units after the edge.
    task automatic step(input logic lv, input int v, input logic per,
                        input logic ps, input logic ab);
        load_valid = lv;
        load_value = WIDTH'(v);
        periodic   = per;
        pause      = ps;
        abort      = ab;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        idle(2);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_expired", int'(expired), 0);
        check("rst_expiries", int'(expiries), 0);
        rst = 1'b0;
        idle(1);
        check("rst_load_ready", int'(load_ready), 1);

        // One-shot load 5
        step(1, 5, 0, 0, 0);
        check("os_count_load", int'(count), 5);
        check("os_busy", int'(busy), 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0, 0);
            check("os_count", int'(count), 5 - k);
            check("os_no_exp", int'(expired), 0);
        end
        step(0, 0, 0, 0, 0);
        check("os_count_end", int'(count), 0);
        check("os_expired", int'(expired), 1);
        check("os_busy_end", int'(busy), 0);
        check("os_ready_end", int'(load_ready), 1);
        check("os_expiries", int'(expiries), 1);
        idle(1);
        check("os_pulse_once", int'(expired), 0);

        // Periodic load 3, 50 cycles, tally wraps on the 16th pulse
        step(1, 3, 1, 0, 0);
        for (int k = 1; k <= 50; k++) begin
            step(0, 0, 0, 0, 0);
            if (k == 1) check("per_c1", int'(count), 2);
            if (k == 3) begin
                check("per_c3", int'(count), 3);
                check("per_exp3", int'(expired), 1);
            end
            if (k == 4) check("per_exp4", int'(expired), 0);
            if (k == 45) check("per_tally15", int'(expiries), 15);
            if (k == 48) begin
                check("per_tally_wrap", int'(expiries), 0);
                check("per_exp48", int'(expired), 1);
            end
        end
        step(0, 0, 0, 0, 1);
        check("per_abort_count", int'(count), 0);
        check("per_abort_hold", int'(expiries), 0);
        idle(1);

        // Pause: load 4, pause 3 cycles at count 2, expiry at handshake+7
        step(1, 4, 0, 0, 0);
        idle(2);
        check("pz_count2", int'(count), 2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            check("pz_hold", int'(count), 2);
            check("pz_paused", int'(paused), 1);
        end
        step(0, 0, 0, 0, 0);
        check("pz_resume", int'(count), 1);
        check("pz_unpaused", int'(paused), 0);
        step(0, 0, 0, 0, 0);
        check("pz_expired", int'(expired), 1);
        idle(1);

        // Load 0 in periodic mode
        step(1, 0, 1, 0, 0);
        check("z_expired", int'(expired), 1);
        check("z_busy", int'(busy), 0);
        check("z_expiries", int'(expiries), 1);
        idle(3);
        check("z_no_more", int'(expired), 0);
        check("z_tally", int'(expiries), 1);

        // Abort with a simultaneous load
        step(1, 10, 0, 0, 0);
        idle(4);
        check("ab_count6", int'(count), 6);
        step(1, 9, 0, 0, 1);
        check("ab_count", int'(count), 0);
        check("ab_busy", int'(busy), 0);
        check("ab_no_exp", int'(expired), 0);
        check("ab_not_ready", int'(load_ready), 0);
        step(1, 9, 0, 0, 0);
        check("ab_reload", int'(count), 9);
        check("ab_busy2", int'(busy), 1);
        step(0, 0, 0, 0, 1);
        idle(1);

        // Reset mid-run
        step(1, 200, 1, 0, 0);
        idle(3);
        check("mr_count197", int'(count), 197);
        rst = 1'b1;
        step(1, 5, 0, 1, 0);
        check("mr_count", int'(count), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_paused", int'(paused), 0);
        check("mr_expiries", int'(expiries), 0);
        rst = 1'b0;
        idle(1);

        // Randomized phase, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            logic lv, per, ps, ab;
            int v;
            lv  = ($urandom_range(0, 99) < 30);
            per = $urandom_range(0, 1) == 1;
            ps  = ($urandom_range(0, 99) < 15);
            ab  = ($urandom_range(0, 99) < 3);
            v   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 7));
            rst = ($urandom_range(0, 399) == 0);
            step(lv, v, per, ps, ab);
        end
        rst = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_countdown_timer
